// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants and state encoding for the byte-serial multi-precision adder.
package multibyte_add_seq_pkg;

    localparam int BYTE_W         = 8;
    localparam int NBYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multibyte_add_seq_cla.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate/propagate products.
module CLA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gen;
    logic       prop;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        // NOTE: every variable gets a default before any branch or loop so no latch is inferred.
        c    = '0;
        gen  = 1'b0;
        prop = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            gen  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen  = gen | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = gen | (prop & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial add/subtract of wide operands, LSB first, with registered carry between bytes.
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    input  logic                   sub,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   zero
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            c_reg;
    logic [IDXW-1:0] idx;
    logic            zacc;

    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;
    logic [7:0]      sum;
    logic            cout;
    logic            byte_zero;

    // Byte select as a shift keeps the index width free of the operand width.
    assign a_shift   = a_reg >> {idx, 3'b000};
    assign b_shift   = b_reg >> {idx, 3'b000};
    assign byte_zero = (sum == 8'd0);

    CLA_8bit u_cla (
        .a    (a_shift[7:0]),
        .b    (b_shift[7:0]),
        .cin  (c_reg),
        .sum  (sum),
        .cout (cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, so an aborted op never leaves stale bytes visible.
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= 1'b0;
            idx       <= '0;
            zacc      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= sub ? ~op_b : op_b;
                        c_reg <= sub ? 1'b1 : in_carry;
                        idx   <= '0;
                        zacc  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IDXW'(i)) result[i*BYTE_W +: BYTE_W] <= sum;
                    end
                    c_reg <= cout;
                    zacc  <= zacc & byte_zero;
                    if (idx == LAST) begin
                        carry_out <= cout;
                        overflow  <= (a_reg[W-1] == b_reg[W-1]) && (sum[7] != a_reg[W-1]);
                        zero      <= zacc & byte_zero;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq: a 4-byte instance driven from a vector table plus a 1-byte instance.
module tb_multibyte_add_seq;

    logic clk;
    logic rst_n;

    logic        in_valid, in_ready, sub, in_carry, out_valid, out_ready;
    logic [31:0] op_a, op_b, result;
    logic        carry_out, overflow, zero;

    logic        in_valid1, in_ready1, sub1, in_carry1, out_valid1, out_ready1;
    logic [7:0]  op_a1, op_b1, result1;
    logic        carry_out1, overflow1, zero1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        ci;
        logic [31:0] r;
        logic        c;
        logic        ov;
        logic        z;
        logic        early;
    } vec_t;

    vec_t vecs[8];

    multibyte_add_seq #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    multibyte_add_seq #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .sub(sub1), .in_carry(in_carry1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .carry_out(carry_out1), .overflow(overflow1), .zero(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept4(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ci);
        @(negedge clk);
        check("in_ready before accept", 64'(in_ready), 64'd1);
        op_a = a; op_b = b; sub = s; in_carry = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept cycle as cycle 1.
    task automatic wait_done4(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid within bound", 64'(out_valid), 64'd1);
    endtask

    task automatic release4();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release in_ready", 64'(in_ready), 64'd1);
        check("release out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic run1(input string name, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic ci, input logic [7:0] r, input logic c, input logic ov, input logic z);
        int lat;
        @(negedge clk);
        op_a1 = a; op_b1 = b; sub1 = s; in_carry1 = ci; in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " out_valid"}, 64'(out_valid1), 64'd1);
        check({name, " latency"}, 64'(lat), 64'd2);
        check({name, " result"}, 64'(result1), 64'(r));
        check({name, " carry"}, 64'(carry_out1), 64'(c));
        check({name, " overflow"}, 64'(overflow1), 64'(ov));
        check({name, " zero"}, 64'(zero1), 64'(z));
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        check({name, " back to idle"}, 64'(in_ready1), 64'd1);
    endtask

    initial begin
        int lat;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; in_carry = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; sub1 = 1'b0; in_carry1 = 1'b0; out_ready1 = 1'b0;

        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({carry_out, overflow, zero}), 64'd0);
        check("reset in_ready1", 64'(in_ready1), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        check("post-reset out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            accept4(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ci);
            if (vecs[i].early) out_ready = 1'b1;
            wait_done4(lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'd5);
            check($sformatf("v%0d result", i), 64'(result), 64'(vecs[i].r));
            check($sformatf("v%0d carry", i), 64'(carry_out), 64'(vecs[i].c));
            check($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].ov));
            check($sformatf("v%0d zero", i), 64'(zero), 64'(vecs[i].z));
            if (vecs[i].early) begin
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                check($sformatf("v%0d early ready leaves DONE", i), 64'(out_valid), 64'd0);
                check($sformatf("v%0d early ready in_ready", i), 64'(in_ready), 64'd1);
            end else begin
                release4();
            end
        end

        // Backpressure: DONE holds for 10 cycles while in_valid is pulsed with new operands.
        accept4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done4(lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                op_a = 32'h0000_0001; op_b = 32'h0000_0001; sub = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check("bp out_valid", 64'(out_valid), 64'd1);
        check("bp result", 64'(result), 64'h2345_6789);
        check("bp flags", 64'({carry_out, overflow, zero}), 64'd0);
        release4();
        check("bp result held in idle", 64'(result), 64'h2345_6789);
        accept4(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        wait_done4(lat);
        check("bp next latency", 64'(lat), 64'd5);
        check("bp next result", 64'(result), 64'h0000_0003);
        release4();

        // Asynchronous reset while idx == 2.
        accept4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-reset result", 64'(result), 64'd0);
        check("mid-reset in_ready", 64'(in_ready), 64'd1);
        check("mid-reset out_valid", 64'(out_valid), 64'd0);
        check("mid-reset flags", 64'({carry_out, overflow, zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done4(lat);
        check("after reset latency", 64'(lat), 64'd5);
        check("after reset result", 64'(result), 64'h2345_6789);
        release4();

        run1("n1 add", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        run1("n1 sub", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
        run1("n1 cin", 8'h0F, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
